// File: rtl/pc_unit.sv
// Program counter with branch/jump/jump-register redirect selection,
// stall-time redirect buffering, a fetch counter and a sticky
// misaligned jump-register flag.
module pc_unit #(
  parameter int unsigned     WIDTH        = 32,
  parameter int unsigned     INC_BYTES    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned     CNT_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [WIDTH-1:0]     branch_offset,
  input  logic                 jump,
  input  logic [25:0]          jump_index,
  input  logic                 jump_reg,
  input  logic [WIDTH-1:0]     reg_target,
  output logic [WIDTH-1:0]     pc_out,
  output logic [WIDTH-1:0]     pc_plus_inc,
  output logic                 redirect_pending,
  output logic [CNT_WIDTH-1:0] fetch_count,
  output logic                 misaligned_err
);

  localparam logic [WIDTH-1:0] INC_VAL    = WIDTH'(INC_BYTES);
  localparam logic [WIDTH-1:0] LOW_MASK   = WIDTH'(INC_BYTES - 1);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~LOW_MASK;

  logic [WIDTH-1:0]     pc_q, pc_d;
  logic                 pend_q, pend_d;
  logic [WIDTH-1:0]     pend_tgt_q, pend_tgt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 mis_q, mis_d;

  logic                 live_redirect;
  logic [WIDTH-1:0]     live_target;
  logic [WIDTH-1:0]     jr_target;
  logic [WIDTH-1:0]     j_target;
  logic [WIDTH-1:0]     br_target;

  assign pc_out           = pc_q;
  assign pc_plus_inc      = pc_q + INC_VAL;
  assign redirect_pending = pend_q;
  assign fetch_count      = cnt_q;
  assign misaligned_err   = mis_q;

  // Candidate targets for each redirect source
  always_comb begin
    jr_target = reg_target & ALIGN_MASK;
    j_target  = {pc_plus_inc[WIDTH-1:28], jump_index, 2'b00};
    br_target = pc_plus_inc + (branch_offset << 2);
  end

  // Priority select of the live redirect: jump_reg > jump > branch
  always_comb begin
    live_redirect = jump_reg | jump | branch_taken;
    live_target   = br_target;
    if (jump_reg) begin
      live_target = jr_target;
    end else if (jump) begin
      live_target = j_target;
    end
  end

  // Next-state: advance, redirect, or hold and buffer during stall
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    cnt_d      = cnt_q;
    mis_d      = mis_q | (jump_reg & ((reg_target & LOW_MASK) != '0));
    if (!stall) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      if (live_redirect) begin
        pc_d   = live_target;
        pend_d = 1'b0;
      end else if (pend_q) begin
        pc_d   = pend_tgt_q;
        pend_d = 1'b0;
      end else begin
        pc_d = pc_plus_inc;
      end
    end else if (live_redirect) begin
      pend_tgt_d = live_target;
      pend_d     = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      cnt_q      <= '0;
      mis_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      cnt_q      <= cnt_d;
      mis_q      <= mis_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: a default instance plus a 4-bit
// counter instance sharing the same stimulus.
module tb_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] reg_target;

  logic [31:0] pc_out, pc_plus_inc;
  logic        redirect_pending, misaligned_err;
  logic [15:0] fetch_count;

  logic [31:0] pc_out4, pc_plus_inc4;
  logic        redirect_pending4, misaligned_err4;
  logic [3:0]  fetch_count4;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_cnt  = 0;

  always #5 clock = ~clock;

  pc_unit dut (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index),
    .jump_reg(jump_reg), .reg_target(reg_target),
    .pc_out(pc_out), .pc_plus_inc(pc_plus_inc),
    .redirect_pending(redirect_pending), .fetch_count(fetch_count),
    .misaligned_err(misaligned_err)
  );

  pc_unit #(.CNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index),
    .jump_reg(jump_reg), .reg_target(reg_target),
    .pc_out(pc_out4), .pc_plus_inc(pc_plus_inc4),
    .redirect_pending(redirect_pending4), .fetch_count(fetch_count4),
    .misaligned_err(misaligned_err4)
  );

  // Count one comparison and report it if it disagrees
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock; track expected fetch count; sample 1 time unit after the edge
  task automatic step();
    @(posedge clock);
    if (reset) exp_cnt = 0;
    else if (!stall) exp_cnt++;
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; jump_reg = 0;
    branch_offset = '0; jump_index = '0; reg_target = '0;
  endtask

  task automatic goto(input logic [31:0] addr);
    idle();
    jump_reg = 1; reg_target = addr;
    step();
    idle();
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_cnt"}, 32'(fetch_count), exp_cnt & 32'hFFFF);
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clock);
    step();
    check("rst_pc", pc_out, 32'h0);
    check("rst_pci", pc_plus_inc, 32'h4);
    check("rst_pend", 32'(redirect_pending), 32'h0);
    check("rst_cnt", 32'(fetch_count), 32'h0);
    check("rst_mis", 32'(misaligned_err), 32'h0);
    check("rst_pc4", pc_out4, 32'h0);
    check("rst_pci4", pc_plus_inc4, 32'h4);
    check("rst_pend4", 32'(redirect_pending4), 32'h0);
    check("rst_cnt4", 32'(fetch_count4), 32'h0);
    check("rst_mis4", 32'(misaligned_err4), 32'h0);

    reset = 0;
    step(); check("seq1", pc_out, 32'h4);
    step(); check("seq2", pc_out, 32'h8);
    step(); check("seq3", pc_out, 32'hC);
    check("seq_cnt", 32'(fetch_count), 32'd3);
    check("seq_pci", pc_plus_inc, 32'h10);

    // Branch backward and forward
    goto(32'h100); check("goto100", pc_out, 32'h100);
    branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
    step(); idle(); check("br_neg", pc_out, 32'hFC);
    goto(32'h100);
    branch_taken = 1; branch_offset = 32'd3;
    step(); idle(); check("br_pos", pc_out, 32'h110);

    // Absolute jump and priority over it
    goto(32'h1000_0040);
    jump = 1; jump_index = 26'h123;
    step(); idle(); check("jump", pc_out, 32'h1000_048C);
    goto(32'h1000_0040);
    jump = 1; jump_index = 26'h123; jump_reg = 1; reg_target = 32'h2000;
    step(); idle(); check("jr_prio", pc_out, 32'h2000);
    jump = 1; jump_index = 26'h10; branch_taken = 1; branch_offset = 32'd1;
    step(); idle(); check("j_over_br", pc_out, 32'h0000_0040);
    check_cnt("pre_stall");

    // Stall with two buffered redirects, newest wins
    goto(32'h20);
    stall = 1; branch_taken = 1; branch_offset = 32'd4;
    step();
    check("st1_pc", pc_out, 32'h20);
    check("st1_pend", 32'(redirect_pending), 32'h1);
    idle(); stall = 1; jump_reg = 1; reg_target = 32'h80;
    step();
    check("st2_pc", pc_out, 32'h20);
    idle(); stall = 1;
    step();
    check("st3_pc", pc_out, 32'h20);
    check("st3_pend", 32'(redirect_pending), 32'h1);
    check_cnt("st3");
    idle();
    step();
    check("rel_pc", pc_out, 32'h80);
    check("rel_pend", 32'(redirect_pending), 32'h0);
    step(); check("rel_seq", pc_out, 32'h84);

    // Live redirect at stall release overrides the buffered one
    stall = 1; jump_reg = 1; reg_target = 32'h200;
    step();
    idle(); branch_taken = 1; branch_offset = 32'd0;
    step(); idle();
    check("ovr_pc", pc_out, 32'h88);
    check("ovr_pend", 32'(redirect_pending), 32'h0);

    // Misaligned jump register is sticky
    check("mis_pre", 32'(misaligned_err), 32'h0);
    goto(32'h46);
    check("mis_pc", pc_out, 32'h44);
    check("mis_set", 32'(misaligned_err), 32'h1);
    for (int i = 0; i < 10; i++) step();
    check("mis_hold", 32'(misaligned_err), 32'h1);
    check("mis_hold_pc", pc_out, 32'h44 + 32'd40);
    reset = 1; step(); reset = 0;
    check("mis_clr", 32'(misaligned_err), 32'h0);

    // Misaligned capture while stalled, with a lower-priority source ignored
    stall = 1; jump_reg = 1; reg_target = 32'h301; jump = 1;
    step(); idle();
    check("mis_stall", 32'(misaligned_err), 32'h1);
    step();
    check("mis_stall_pc", pc_out, 32'h300);
    reset = 1; step(); reset = 0;

    // Address wrap and 4-bit counter wrap after 16 advances
    goto(32'hFFFF_FFFC);
    check("wrap_pci", pc_plus_inc, 32'h0);
    step();
    check("wrap_pc", pc_out, 32'h0);
    for (int i = 0; i < 14; i++) step();
    check("cnt16", 32'(fetch_count), 32'd16);
    check("cnt4_wrap", 32'(fetch_count4), 32'd0);
    check("pc4", pc_out4, 32'd56);

    // Reset during stall with a buffered redirect
    stall = 1; jump_reg = 1; reg_target = 32'h80;
    step();
    check("rs_pend", 32'(redirect_pending), 32'h1);
    reset = 1;
    step();
    check("rs_pc", pc_out, 32'h0);
    check("rs_pend0", 32'(redirect_pending), 32'h0);
    check("rs_cnt", 32'(fetch_count), 32'h0);
    reset = 0; idle();
    step();
    check("rs_after", pc_out, 32'h4);
    check_cnt("end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
